// File: rtl/vscale_hasti_core_arbiter.sv
// vscale_hasti_core_arbiter
// Merges the data-side HASTI master ports of all cores onto the single
// write-capable port of the shared SRAM. Each core's address phase is parked
// in a per-core buffer (FREE -> PEND), a round-robin grant forwards one
// buffered request per cycle to the slave (PEND -> ACTIVE), and the core's
// data phase is stalled with hready low until its slave data phase completes.
module vscale_hasti_core_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic [N_MASTERS*AW-1:0] m_haddr,
    input  logic [N_MASTERS-1:0]    m_hwrite,
    input  logic [N_MASTERS*3-1:0]  m_hsize,
    input  logic [N_MASTERS*2-1:0]  m_htrans,
    input  logic [N_MASTERS*DW-1:0] m_hwdata,
    output logic [N_MASTERS*DW-1:0] m_hrdata,
    output logic [N_MASTERS-1:0]    m_hready,
    output logic [N_MASTERS-1:0]    m_hresp,
    output logic [AW-1:0]           s_haddr,
    output logic                    s_hwrite,
    output logic [2:0]              s_hsize,
    output logic [1:0]              s_htrans,
    output logic [2:0]              s_hburst,
    output logic                    s_hmastlock,
    output logic [3:0]              s_hprot,
    output logic [DW-1:0]           s_hwdata,
    input  logic [DW-1:0]           s_hrdata,
    input  logic                    s_hready,
    input  logic                    s_hresp
);

    localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_ACTIVE = 2'd2
    } core_state_t;

    core_state_t          state_q   [N_MASTERS];
    logic [AW-1:0]        buf_addr  [N_MASTERS];
    logic                 buf_write [N_MASTERS];
    logic [2:0]           buf_size  [N_MASTERS];
    logic [DW-1:0]        rdata_q   [N_MASTERS];

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] pend;
    logic [N_MASTERS-1:0] active;
    logic [N_MASTERS-1:0] ready;
    logic [N_MASTERS-1:0] load;

    logic [PW-1:0]        rr_q;
    logic [PW-1:0]        rr_win;
    logic [PW:0]          rr_sum;
    logic [PW-1:0]        win;
    logic                 any_pend;
    logic                 lock_vld_q;
    logic [PW-1:0]        lock_idx_q;
    logic                 owner_vld_q;
    logic [PW-1:0]        owner_q;

    logic [AW-1:0]        haddr_q;
    logic                 hwrite_q;
    logic [2:0]           hsize_q;

    // Decode requests and derive per-core ready/load from the core state.
    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            req[i]    = (m_htrans[i*2 +: 2] == HTRANS_NONSEQ) ||
                        (m_htrans[i*2 +: 2] == HTRANS_SEQ);
            pend[i]   = (state_q[i] == ST_PEND);
            active[i] = (state_q[i] == ST_ACTIVE);
            ready[i]  = (state_q[i] == ST_FREE) || (active[i] && s_hready);
            load[i]   = ready[i] && req[i];
        end
    end

    assign m_hready = ready;

    // Round-robin search over pending cores, lowest offset from rr_q wins.
    always_comb begin
        rr_win   = '0;
        any_pend = 1'b0;
        rr_sum   = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            rr_sum = {1'b0, rr_q} + (PW+1)'(k);
            if (rr_sum >= (PW+1)'(N_MASTERS)) begin
                rr_sum = rr_sum - (PW+1)'(N_MASTERS);
            end
            if (pend[rr_sum[PW-1:0]]) begin
                rr_win   = rr_sum[PW-1:0];
                any_pend = 1'b1;
            end
        end
    end

    // A grant shown during a slave wait state stays put until accepted,
    // even if a newly buffered core would now win the round-robin search.
    assign win = lock_vld_q ? lock_idx_q : rr_win;

    // Per-core FREE/PEND/ACTIVE state machine.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                state_q[i] <= ST_FREE;
            end
        end else begin
            for (int i = 0; i < N_MASTERS; i++) begin
                case (state_q[i])
                    ST_FREE: begin
                        if (load[i]) state_q[i] <= ST_PEND;
                    end
                    ST_PEND: begin
                        if (s_hready && (win == PW'(i))) state_q[i] <= ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        if (s_hready) state_q[i] <= load[i] ? ST_PEND : ST_FREE;
                    end
                    default: state_q[i] <= ST_FREE;
                endcase
            end
        end
    end

    // Capture each core's address phase whenever the core sees hready high.
    always_ff @(posedge hclk) begin
        for (int i = 0; i < N_MASTERS; i++) begin
            if (load[i]) begin
                buf_addr[i]  <= m_haddr[i*AW +: AW];
                buf_write[i] <= m_hwrite[i];
                buf_size[i]  <= m_hsize[i*3 +: 3];
            end
        end
    end

    // Round-robin pointer, wait-state grant lock and data-phase owner.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            rr_q        <= '0;
            lock_vld_q  <= 1'b0;
            lock_idx_q  <= '0;
            owner_vld_q <= 1'b0;
            owner_q     <= '0;
        end else if (s_hready) begin
            lock_vld_q  <= 1'b0;
            owner_vld_q <= any_pend;
            if (any_pend) begin
                owner_q <= win;
                rr_q    <= (win == PW'(N_MASTERS - 1)) ? '0 : win + PW'(1);
            end
        end else if (any_pend && !lock_vld_q) begin
            lock_vld_q <= 1'b1;
            lock_idx_q <= win;
        end
    end

    // Remember the last presented address phase so IDLE cycles hold it.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
        end else if (any_pend) begin
            haddr_q  <= s_haddr;
            hwrite_q <= s_hwrite;
            hsize_q  <= s_hsize;
        end
    end

    // Slave address phase: the granted buffer, or IDLE with held fields.
    always_comb begin
        s_htrans = any_pend ? HTRANS_NONSEQ : HTRANS_IDLE;
        s_haddr  = haddr_q;
        s_hwrite = hwrite_q;
        s_hsize  = hsize_q;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (any_pend && (win == PW'(i))) begin
                s_haddr  = buf_addr[i];
                s_hwrite = buf_write[i];
                s_hsize  = buf_size[i];
            end
        end
    end

    // Write data follows the core that owns the slave data phase.
    always_comb begin
        s_hwdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (owner_vld_q && (owner_q == PW'(i))) begin
                s_hwdata = m_hwdata[i*DW +: DW];
            end
        end
    end

    // Keep the last read data seen by each core during its data phase.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (active[i]) rdata_q[i] <= s_hrdata;
            end
        end
    end

    // Read data and response pass through only to the data-phase owner.
    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            m_hrdata[i*DW +: DW] = active[i] ? s_hrdata : rdata_q[i];
            m_hresp[i]           = active[i] ? s_hresp : 1'b0;
        end
    end

    assign s_hburst    = 3'b000;
    assign s_hmastlock = 1'b0;
    assign s_hprot     = 4'b0000;

endmodule

// File: doc/vscale_hasti_core_arbiter.md
Name: vscale_hasti_core_arbiter

Overview:
- Upstream feeder of the shared dual-port SRAM's single write-capable port.
- Merges the data-side HASTI (AHB-lite) master ports of all cores onto one slave port using round-robin arbitration.
- Accepts every core's address phase into a per-core holding buffer. Stalls that core's data phase with hready low until its transfer completes at the slave.

Parameters:
- N_MASTERS, `NUM_CORES, number of core master ports (1..8).
- AW, `HASTI_ADDR_WIDTH (32), address width.
- DW, `HASTI_BUS_WIDTH (32), data width.

Ports:
- hclk  in  1  clock
- hreset  in  1  asynchronous active-high reset
- m_haddr  in  N_MASTERS*AW  per-core address, core i at bits [i*AW +: AW]
- m_hwrite  in  N_MASTERS  per-core write flag
- m_hsize  in  N_MASTERS*3  per-core transfer size
- m_htrans  in  N_MASTERS*2  per-core transfer type
- m_hwdata  in  N_MASTERS*DW  per-core write data (data phase)
- m_hrdata  out  N_MASTERS*DW  per-core read data
- m_hready  out  N_MASTERS  per-core ready
- m_hresp  out  N_MASTERS  per-core response
- s_haddr, s_hwrite, s_hsize, s_htrans  out  AW/1/3/2  slave address phase
- s_hburst  out  3  constant SINGLE (0)
- s_hmastlock  out  1  constant 0
- s_hprot  out  4  constant 0
- s_hwdata  out  DW  slave write data
- s_hrdata  in  DW  slave read data
- s_hready  in  1  slave ready
- s_hresp  in  1  slave response

Behaviour:
- Reset (async, hreset=1):
  - all per-core states FREE; rr pointer 0; data-phase owner invalid.
  - m_hready all 1; m_hresp all OKAY; m_hrdata 0.
  - s_htrans IDLE; s_haddr 0; s_hwdata 0.
- Transfer request: core i requests when m_htrans[i] is NONSEQ or SEQ. IDLE and BUSY are not requests.
- Per-core FSM, states FREE / PEND / ACTIVE:
  - FREE->PEND: at a clock edge with m_hready[i]=1 and a request. Latches haddr, hwrite, and hsize into the core's buffer.
  - PEND->ACTIVE: at an edge where core i is granted and s_hready=1. Owner register <= i.
  - ACTIVE->FREE: at an edge where s_hready=1. If core i presents a new request in that same cycle, the transition is ACTIVE->PEND instead (back-to-back).
- m_hready[i] is 1 only when the core is FREE, or when it is ACTIVE and s_hready=1; it is 0 in PEND and in stalled ACTIVE.
  - m_hrdata[i] = s_hrdata and m_hresp[i] = s_hresp only while core i is ACTIVE.
  - Otherwise m_hresp[i] = OKAY and m_hrdata[i] holds its last value.
- Grant (combinational):
  - Chooses among PEND cores, starting at rr pointer, ascending with wrap.
  - Drives s_htrans=NONSEQ plus the buffered address, write flag, and size of the winner.
  - If no core is PEND: s_htrans=IDLE and the other address-phase signals hold their previous values.
  - rr pointer <= winner+1 (mod N_MASTERS) when the grant is accepted (s_hready=1).
- s_hwdata = m_hwdata[owner] while an owner is valid; otherwise 0.
- Minimum latency:
  - Request accepted at edge T; slave address phase in cycle T+1; slave data phase and m_hready high in cycle T+2.
  - Exactly one wait state per transfer with s_hready=1.
  - One core alone sustains one transfer per 2 cycles.
  - With two or more cores contending, the slave sustains one transfer per cycle (address phase of one core overlaps data phase of another).
- s_hready=0: no state changes, grant frozen, all slave outputs held stable.
- Same-cycle requests from several FREE cores: all are latched to PEND; they are served in round-robin order.
- Reset mid-operation: any outstanding slave transfer is abandoned; buffered requests are dropped.
- N_MASTERS=1: pointer constant 0; behaviour otherwise identical.

Test Plan:
- Single write: core0 NONSEQ write to 0x10, size 2, data 0xDEADBEEF.
  - Cycle T+1: s_htrans NONSEQ, s_haddr 0x10.
  - Cycle T+2: s_hwdata 0xDEADBEEF, m_hready[0] 0 then 1.
- Simultaneous reads: core0 reads 0x20, core1 reads 0x24 at the same edge.
  - Slave address phases at T+1 (core0) and T+2 (core1).
  - m_hrdata[0] valid at T+2, m_hrdata[1] valid at T+3.
- Fairness: 2 cores issue continuous back-to-back reads for 20 cycles.
  - Grants alternate 0,1,0,1.
  - Each core completes 10 transfers (±1); no starvation.
- Slave wait state: s_hready held 0 for 3 cycles during core1 data phase.
  - m_hready[1] stays 0 for those cycles.
  - Pending core0 address phase held stable; completes one cycle after s_hready rises.
- Response pass-through: s_hresp=ERROR during core0 data phase.
  - m_hresp[0]=1 in that cycle only; core1 sees OKAY.
- Reset mid-transfer: assert hreset while core1 is PEND and core0 is ACTIVE.
  - m_hready goes all 1 and s_htrans goes IDLE asynchronously.
  - After release, the first request is granted starting from core0.
